// File: rtl/jmp_fetch_unit.sv
// Fetch stage holding PC and the IF/ID register.
// Resolves JMP/CALL in decode with a one-bubble redirect.
module jmp_fetch_unit #(
    parameter logic [7:0] RESET_PC        = 8'h00,
    parameter logic [7:0] NOP             = 8'h00,
    parameter bit         USE_BOOT_VECTOR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    input  logic       stall_d,
    input  logic [1:0] SHD,
    input  logic [7:0] rb_data,
    input  logic [7:0] alu_res_ex,
    input  logic [7:0] data_out_mem,
    input  logic       stall_ext,
    input  logic       redirect_ex,
    input  logic [7:0] redirect_pc_ex,
    output logic [7:0] IR,
    output logic [7:0] pc_d,
    output logic [7:0] pc_plus1_d,
    output logic       valid_d,
    output logic       jmp_taken_d,
    output logic       call_d
);

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_n;
    logic [7:0] ir_q, ir_d;
    logic [7:0] dpc_q, dpc_d;
    logic       valid_q, valid_d_n;
    logic [7:0] target;
    logic       is_jmp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= USE_BOOT_VECTOR ? BOOT : RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    if (!stall_ext) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        unique case (SHD)
            2'd1:    target = alu_res_ex;
            2'd2:    target = data_out_mem;
            default: target = rb_data;
        endcase
    end

    assign is_jmp = (ir_q[7:4] == 4'd11) & ~ir_q[3] & valid_q;

    assign jmp_taken_d = is_jmp & ~stall_d & ~stall_ext
                       & ~redirect_ex & (state_q == RUN);
    assign call_d      = jmp_taken_d & ir_q[2];

    // Datapath next-state; the order below is the redirect priority.
    always_comb begin
        pc_n      = pc_q;
        ir_d      = ir_q;
        dpc_d     = dpc_q;
        valid_d_n = valid_q;
        if (state_q == BOOT) begin
            if (!stall_ext) pc_n = imem_data;
        end else if (stall_ext) begin
            pc_n = pc_q;
        end else if (redirect_ex) begin
            pc_n      = redirect_pc_ex;
            ir_d      = NOP;
            valid_d_n = 1'b0;
        end else if (stall_d) begin
            pc_n = pc_q;
        end else if (jmp_taken_d) begin
            pc_n      = target;
            ir_d      = NOP;
            valid_d_n = 1'b0;
        end else begin
            ir_d      = imem_data;
            dpc_d     = pc_q;
            pc_n      = pc_q + 8'd1;
            valid_d_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            ir_q    <= NOP;
            dpc_q   <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_n;
            ir_q    <= ir_d;
            dpc_q   <= dpc_d;
            valid_q <= valid_d_n;
        end
    end

    assign imem_addr  = pc_q;
    assign IR         = ir_q;
    assign pc_d       = dpc_q;
    assign pc_plus1_d = dpc_q + 8'd1;
    assign valid_d    = valid_q;

endmodule

// File: tb/tb_jmp_fetch_unit.sv
// Directed and random checks of jmp_fetch_unit against a
// cycle-level reference model of the fetch rules.
module tb_jmp_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       stall_d;
    logic [1:0] SHD;
    logic [7:0] rb_data;
    logic [7:0] alu_res_ex;
    logic [7:0] data_out_mem;
    logic       stall_ext;
    logic       redirect_ex;
    logic [7:0] redirect_pc_ex;
    logic [7:0] IR;
    logic [7:0] pc_d;
    logic [7:0] pc_plus1_d;
    logic       valid_d;
    logic       jmp_taken_d;
    logic       call_d;

    logic [7:0] imem [256];

    int errors = 0;
    int checks = 0;

    logic [7:0] m_pc, m_ir, m_pcd;
    logic       m_valid, m_boot;

    always #5 clk = ~clk;

    assign imem_data = imem[imem_addr];

    jmp_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall_d        (stall_d),
        .SHD            (SHD),
        .rb_data        (rb_data),
        .alu_res_ex     (alu_res_ex),
        .data_out_mem   (data_out_mem),
        .stall_ext      (stall_ext),
        .redirect_ex    (redirect_ex),
        .redirect_pc_ex (redirect_pc_ex),
        .IR             (IR),
        .pc_d           (pc_d),
        .pc_plus1_d     (pc_plus1_d),
        .valid_d        (valid_d),
        .jmp_taken_d    (jmp_taken_d),
        .call_d         (call_d)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 8'h00;
        m_ir    = 8'h00;
        m_pcd   = 8'h00;
        m_valid = 1'b0;
        m_boot  = 1'b1;
    endtask

    function automatic logic m_jt();
        return (m_ir[7:4] == 4'hB) && !m_ir[3] && m_valid
            && !stall_d && !stall_ext && !redirect_ex && !m_boot;
    endfunction

    function automatic logic [7:0] m_target();
        if (SHD == 2'd1) return alu_res_ex;
        if (SHD == 2'd2) return data_out_mem;
        return rb_data;
    endfunction

    task automatic model_tick();
        if (m_boot) begin
            if (!stall_ext) begin
                m_pc   = imem[m_pc];
                m_boot = 1'b0;
            end
        end else if (stall_ext) begin
        end else if (redirect_ex) begin
            m_pc    = redirect_pc_ex;
            m_ir    = 8'h00;
            m_valid = 1'b0;
        end else if (stall_d) begin
        end else if (m_jt()) begin
            m_pc    = m_target();
            m_ir    = 8'h00;
            m_valid = 1'b0;
        end else begin
            m_ir    = imem[m_pc];
            m_pcd   = m_pc;
            m_pc    = m_pc + 8'd1;
            m_valid = 1'b1;
        end
    endtask

    task automatic check_model();
        logic jt;
        jt = m_jt();
        chk("imem_addr", imem_addr, m_pc);
        chk("IR", IR, m_ir);
        chk("pc_d", pc_d, m_pcd);
        chk("pc_plus1_d", pc_plus1_d, m_pcd + 8'd1);
        chk("valid_d", {7'd0, valid_d}, {7'd0, m_valid});
        chk("jmp_taken_d", {7'd0, jmp_taken_d}, {7'd0, jt});
        chk("call_d", {7'd0, call_d}, {7'd0, jt & m_ir[2]});
    endtask

    task automatic step();
        #1;
        check_model();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall_d        = 1'b0;
        SHD            = 2'd0;
        rb_data        = 8'h00;
        alu_res_ex     = 8'h00;
        data_out_mem   = 8'h00;
        stall_ext      = 1'b0;
        redirect_ex    = 1'b0;
        redirect_pc_ex = 8'h00;
    endtask

    task automatic go_to(input logic [7:0] a);
        redirect_ex    = 1'b1;
        redirect_pc_ex = a;
        step();
        redirect_ex    = 1'b0;
        step();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"}, imem_addr, 8'h00);
        chk({tag, "_ir"}, IR, 8'h00);
        chk({tag, "_pcd"}, pc_d, 8'h00);
        chk({tag, "_valid"}, {7'd0, valid_d}, 8'h00);
        chk({tag, "_jt"}, {7'd0, jmp_taken_d}, 8'h00);
        chk({tag, "_call"}, {7'd0, call_d}, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 8'h01;
        imem[8'h00] = 8'h20;
        imem[8'h20] = 8'hB1;
        imem[8'h10] = 8'hB6;
        imem[8'h40] = 8'h5A;
        idle_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_reset("reset");
        model_reset();

        // Boot vector
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("boot_addr", imem_addr, 8'h20);
        step();
        chk("boot_ir", IR, 8'hB1);
        chk("boot_pcd", pc_d, 8'h20);
        chk("boot_valid", {7'd0, valid_d}, 8'h01);

        // JMP R1 via register file
        SHD     = 2'd0;
        rb_data = 8'h40;
        #1;
        chk("jmp_jt", {7'd0, jmp_taken_d}, 8'h01);
        chk("jmp_call", {7'd0, call_d}, 8'h00);
        step();
        chk("jmp_bubble_ir", IR, 8'h00);
        chk("jmp_bubble_valid", {7'd0, valid_d}, 8'h00);
        chk("jmp_addr", imem_addr, 8'h40);
        step();
        chk("jmp_tgt_ir", IR, 8'h5A);
        idle_inputs();

        // CALL via EX bypass, then MEM bypass
        go_to(8'h10);
        chk("call_ir", IR, 8'hB6);
        chk("call_pcd", pc_d, 8'h10);
        SHD        = 2'd1;
        alu_res_ex = 8'h80;
        #1;
        chk("call_c", {7'd0, call_d}, 8'h01);
        chk("call_ret", pc_plus1_d, 8'h11);
        step();
        chk("call_alu_addr", imem_addr, 8'h80);
        idle_inputs();
        go_to(8'h10);
        SHD          = 2'd2;
        data_out_mem = 8'h90;
        step();
        chk("call_mem_addr", imem_addr, 8'h90);
        idle_inputs();

        // Decode stall across two cycles
        go_to(8'h20);
        stall_d = 1'b1;
        step();
        step();
        chk("stall_ir", IR, 8'hB1);
        chk("stall_addr", imem_addr, 8'h21);
        stall_d    = 1'b0;
        SHD        = 2'd1;
        alu_res_ex = 8'h77;
        step();
        chk("stall_tgt", imem_addr, 8'h77);
        idle_inputs();

        // EX redirect beats the decode jump
        go_to(8'h20);
        stall_d        = 1'b1;
        redirect_ex    = 1'b1;
        redirect_pc_ex = 8'h33;
        step();
        chk("prio_addr", imem_addr, 8'h33);
        chk("prio_ir", IR, 8'h00);
        idle_inputs();
        go_to(8'h20);
        stall_ext      = 1'b1;
        stall_d        = 1'b1;
        redirect_ex    = 1'b1;
        redirect_pc_ex = 8'h33;
        step();
        chk("ext_addr", imem_addr, 8'h21);
        chk("ext_ir", IR, 8'hB1);
        idle_inputs();

        // PC wrap
        go_to(8'hFE);
        step();
        chk("wrap_addr", imem_addr, 8'h00);
        chk("wrap_pcd", pc_d, 8'hFF);

        // Reset in the middle of a stalled jump
        go_to(8'h20);
        stall_d = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();

        // Random traffic
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(3) == 0)
                imem[i] = {4'hB, 1'b0, 3'($urandom)};
            else
                imem[i] = 8'($urandom);
        end
        for (int n = 0; n < 600; n++) begin
            stall_d        = ($urandom_range(3) == 0);
            stall_ext      = ($urandom_range(7) == 0);
            redirect_ex    = ($urandom_range(9) == 0);
            redirect_pc_ex = 8'($urandom);
            SHD            = 2'($urandom);
            rb_data        = 8'($urandom);
            alu_res_ex     = 8'($urandom);
            data_out_mem   = 8'($urandom);
            if (n == 300) begin
                rst_n = 1'b0;
                #1;
                chk_reset("rndrst");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
